multicycle_ctrl: RTL and testbench

//  Main control FSM of the multicycle MIPS datapath. It drives the ALU: issues the 4-bit ALU op code each

---
 rtl/multicycle_ctrl_pkg.sv | 73 +++++++
 rtl/multicycle_ctrl_if.sv | 36 +++
 rtl/multicycle_ctrl_alu_decoder.sv | 31 +++
 rtl/multicycle_ctrl.sv | 131 +++++++++++++
 tb/tb_multicycle_ctrl.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS controller: ALU op codes, opcode/funct values,
// controller state encoding and the ALU decoder mode.
package multicycle_ctrl_pkg;

    localparam int OP_W = 4;
    localparam int ST_W = 4;

    // ALU op codes, shared with the ALU itself
    localparam logic [OP_W-1:0] ALU_AND = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [OP_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [5:0] OPC_R    = 6'b000000;
    localparam logic [5:0] OPC_J    = 6'b000010;
    localparam logic [5:0] OPC_BEQ  = 6'b000100;
    localparam logic [5:0] OPC_ADDI = 6'b001000;
    localparam logic [5:0] OPC_ORI  = 6'b001101;
    localparam logic [5:0] OPC_LW   = 6'b100011;
    localparam logic [5:0] OPC_SW   = 6'b101011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [1:0] SRCB_REGB   = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [ST_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_RTWB   = 4'd7,
        S_BEQ    = 4'd8,
        S_IEX    = 4'd9,
        S_IWB    = 4'd10,
        S_JMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        MODE_ADD   = 2'd0,
        MODE_SUB   = 2'd1,
        MODE_FUNCT = 2'd2,
        MODE_OR    = 2'd3
    } alu_mode_t;

    function automatic logic opcode_supported(input logic [5:0] op);
        logic ok;
        case (op)
            OPC_R, OPC_J, OPC_BEQ, OPC_ADDI, OPC_ORI, OPC_LW, OPC_SW: ok = 1'b1;
            default:                                                  ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: instruction fields and zero flag in, enables/selects out.
// No handshake: every signal is a plain per-cycle level, the controller is the master.
interface multicycle_ctrl_if;
    import multicycle_ctrl_pkg::*;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic            zero;
    logic [OP_W-1:0] alu_op;
    logic            alu_src_a;
    logic [1:0]      alu_src_b;
    logic [1:0]      pc_source;
    logic            pc_en;
    logic            ior_d;
    logic            mem_read;
    logic            mem_write;
    logic            ir_write;
    logic            reg_dst;
    logic            mem_to_reg;
    logic            reg_write;
    logic            illegal;
    logic [ST_W-1:0] state;

    modport master (
        input  opcode, funct, zero,
        output alu_op, alu_src_a, alu_src_b, pc_source, pc_en, ior_d, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal, state
    );

    modport slave (
        output opcode, funct, zero,
        input  alu_op, alu_src_a, alu_src_b, pc_source, pc_en, ior_d, mem_read,
               mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal, state
    );

endinterface

// File: rtl/multicycle_ctrl_alu_decoder.sv
// Maps the controller's coarse ALU mode (and funct for R-type) onto the 4-bit ALU op code.
module multicycle_ctrl_alu_decoder
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]      funct,
    input  alu_mode_t       alu_mode,
    output logic [OP_W-1:0] alu_op
);

    always_comb begin
        alu_op = ALU_ADD;
        case (alu_mode)
            MODE_ADD: alu_op = ALU_ADD;
            MODE_SUB: alu_op = ALU_SUB;
            MODE_OR:  alu_op = ALU_OR;
            MODE_FUNCT: begin
                case (funct)
                    FN_ADD, FN_ADDU: alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: alu_op = ALU_SUB;
                    FN_AND:          alu_op = ALU_AND;
                    FN_OR:           alu_op = ALU_OR;
                    FN_NOR:          alu_op = ALU_NOR;
                    FN_SLT:          alu_op = ALU_SLT;
                    default:         alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: sequences fetch/decode/execute/memory/writeback
// and drives Moore-decoded enables and mux selects (beq pc_en follows zero combinationally).
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    multicycle_ctrl_if.master  bus
);

    state_t    state_q;
    state_t    state_d;
    alu_mode_t alu_mode;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OPC_LW, OPC_SW:    state_d = S_MEMADR;
                    OPC_R:             state_d = S_RTEX;
                    OPC_BEQ:           state_d = S_BEQ;
                    OPC_ADDI, OPC_ORI: state_d = S_IEX;
                    OPC_J:             state_d = S_JMP;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (bus.opcode == OPC_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_d = S_MEMWB;
            S_RTEX:   state_d = S_RTWB;
            S_IEX:    state_d = S_IWB;
            // MEMWB, MEMWR, RTWB, BEQ, IWB, JMP and unused codes all return to FETCH
            default:  state_d = S_FETCH;
        endcase
    end

    // While reset is held the selects show FETCH values and every strobe is suppressed,
    // so an aborted instruction cannot finish a write in its last cycle.
    always_comb begin
        alu_mode       = MODE_ADD;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = SRCB_REGB;
        bus.pc_source  = PCSRC_ALU;
        bus.pc_en      = 1'b0;
        bus.ior_d      = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_write  = 1'b0;
        bus.illegal    = 1'b0;
        if (reset) begin
            bus.alu_src_b = SRCB_FOUR;
        end else begin
            case (state_q)
                S_FETCH: begin
                    bus.mem_read  = 1'b1;
                    bus.ir_write  = 1'b1;
                    bus.alu_src_b = SRCB_FOUR;
                    bus.pc_en     = 1'b1;
                end
                S_DECODE: begin
                    bus.alu_src_b = SRCB_IMM_SH;
                    bus.illegal   = !opcode_supported(bus.opcode);
                end
                S_MEMADR: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                end
                S_MEMRD: begin
                    bus.ior_d    = 1'b1;
                    bus.mem_read = 1'b1;
                end
                S_MEMWB: begin
                    bus.mem_to_reg = 1'b1;
                    bus.reg_write  = 1'b1;
                end
                S_MEMWR: begin
                    bus.ior_d     = 1'b1;
                    bus.mem_write = 1'b1;
                end
                S_RTEX: begin
                    bus.alu_src_a = 1'b1;
                    alu_mode      = MODE_FUNCT;
                end
                S_RTWB: begin
                    bus.reg_dst   = 1'b1;
                    bus.reg_write = 1'b1;
                end
                S_BEQ: begin
                    bus.alu_src_a = 1'b1;
                    alu_mode      = MODE_SUB;
                    bus.pc_source = PCSRC_ALUOUT;
                    bus.pc_en     = bus.zero;
                end
                S_IEX: begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = SRCB_IMM;
                    alu_mode      = (bus.opcode == OPC_ORI) ? MODE_OR : MODE_ADD;
                end
                S_IWB: begin
                    bus.reg_write = 1'b1;
                end
                S_JMP: begin
                    bus.pc_source = PCSRC_JUMP;
                    bus.pc_en     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    multicycle_ctrl_alu_decoder u_alu_decoder (
        .funct    (bus.funct),
        .alu_mode (alu_mode),
        .alu_op   (bus.alu_op)
    );

    assign bus.state = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per-instruction expected cycle records go into a queue,
// a negedge monitor pops one record per cycle and compares the full control word.
module tb_multicycle_ctrl;

    localparam int W = 22;

    // strobe bits: {pc_en, ior_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal}
    localparam logic [8:0] E_NONE = 9'h000;
    localparam logic [8:0] E_PC   = 9'h100;
    localparam logic [8:0] E_IORD = 9'h080;
    localparam logic [8:0] E_MRD  = 9'h040;
    localparam logic [8:0] E_MWR  = 9'h020;
    localparam logic [8:0] E_IRW  = 9'h010;
    localparam logic [8:0] E_RDST = 9'h008;
    localparam logic [8:0] E_M2R  = 9'h004;
    localparam logic [8:0] E_RW   = 9'h002;
    localparam logic [8:0] E_ILL  = 9'h001;

    localparam logic [3:0] A_AND = 4'b0000;
    localparam logic [3:0] A_OR  = 4'b0001;
    localparam logic [3:0] A_ADD = 4'b0010;
    localparam logic [3:0] A_SUB = 4'b0110;
    localparam logic [3:0] A_SLT = 4'b0111;
    localparam logic [3:0] A_NOR = 4'b1100;

    localparam logic [5:0] O_R = 6'b000000, O_J = 6'b000010, O_BEQ = 6'b000100, O_ADDI = 6'b001000;
    localparam logic [5:0] O_ORI = 6'b001101, O_LW = 6'b100011, O_SW = 6'b101011;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [W-1:0] exp_q[$];
    int total = 0;
    int bad = 0;

    multicycle_ctrl_if bus();

    multicycle_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [3:0] ref_rtype_op(input logic [5:0] fn);
        logic [3:0] r;
        case (fn)
            6'b100000, 6'b100001: r = A_ADD;
            6'b100010, 6'b100011: r = A_SUB;
            6'b100100:            r = A_AND;
            6'b100101:            r = A_OR;
            6'b100111:            r = A_NOR;
            6'b101010:            r = A_SLT;
            default:              r = A_ADD;
        endcase
        return r;
    endfunction

    task automatic expect_cycle(input logic [3:0] st, input logic [3:0] op, input logic sa,
                                input logic [1:0] sb, input logic [1:0] ps, input logic [8:0] en);
        exp_q.push_back({st, op, sa, sb, ps, en});
    endtask

    // Pushes the whole expected cycle sequence of one instruction, then lets it run.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int n;
        n = 2;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        expect_cycle(4'd0, A_ADD, 1'b0, 2'b01, 2'b00, E_PC | E_MRD | E_IRW);
        case (op)
            O_LW, O_SW, O_R, O_BEQ, O_ADDI, O_ORI, O_J:
                expect_cycle(4'd1, A_ADD, 1'b0, 2'b11, 2'b00, E_NONE);
            default:
                expect_cycle(4'd1, A_ADD, 1'b0, 2'b11, 2'b00, E_ILL);
        endcase
        case (op)
            O_LW: begin
                expect_cycle(4'd2, A_ADD, 1'b1, 2'b10, 2'b00, E_NONE);
                expect_cycle(4'd3, A_ADD, 1'b0, 2'b00, 2'b00, E_IORD | E_MRD);
                expect_cycle(4'd4, A_ADD, 1'b0, 2'b00, 2'b00, E_M2R | E_RW);
                n = 5;
            end
            O_SW: begin
                expect_cycle(4'd2, A_ADD, 1'b1, 2'b10, 2'b00, E_NONE);
                expect_cycle(4'd5, A_ADD, 1'b0, 2'b00, 2'b00, E_IORD | E_MWR);
                n = 4;
            end
            O_R: begin
                expect_cycle(4'd6, ref_rtype_op(fn), 1'b1, 2'b00, 2'b00, E_NONE);
                expect_cycle(4'd7, A_ADD, 1'b0, 2'b00, 2'b00, E_RDST | E_RW);
                n = 4;
            end
            O_BEQ: begin
                expect_cycle(4'd8, A_SUB, 1'b1, 2'b00, 2'b01, z ? E_PC : E_NONE);
                n = 3;
            end
            O_ADDI, O_ORI: begin
                expect_cycle(4'd9, (op == O_ORI) ? A_OR : A_ADD, 1'b1, 2'b10, 2'b00, E_NONE);
                expect_cycle(4'd10, A_ADD, 1'b0, 2'b00, 2'b00, E_RW);
                n = 4;
            end
            O_J: begin
                expect_cycle(4'd11, A_ADD, 1'b0, 2'b00, 2'b10, E_PC);
                n = 3;
            end
            default: n = 2;
        endcase
        repeat (n) @(posedge clk);
        #1;
    endtask

    // lw aborted by a two-cycle reset while in its address-calculation cycle.
    task automatic reset_mid_lw();
        bus.opcode = O_LW;
        bus.funct  = 6'b000000;
        bus.zero   = 1'b0;
        expect_cycle(4'd0, A_ADD, 1'b0, 2'b01, 2'b00, E_PC | E_MRD | E_IRW);
        expect_cycle(4'd1, A_ADD, 1'b0, 2'b11, 2'b00, E_NONE);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        expect_cycle(4'd2, A_ADD, 1'b0, 2'b01, 2'b00, E_NONE);
        expect_cycle(4'd0, A_ADD, 1'b0, 2'b01, 2'b00, E_NONE);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W-1:0] act;
        logic [W-1:0] exp_v;
        if (exp_q.size() != 0) begin
            act = {bus.state, bus.alu_op, bus.alu_src_a, bus.alu_src_b, bus.pc_source,
                   bus.pc_en, bus.ior_d, bus.mem_read, bus.mem_write, bus.ir_write,
                   bus.reg_dst, bus.mem_to_reg, bus.reg_write, bus.illegal};
            exp_v = exp_q.pop_front();
            total++;
            if (act !== exp_v) begin
                bad++;
                $display("FAIL ctrl_word t=%0t actual=%06h required=%06h", $time, act, exp_v);
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [5:0] op_tab[7];
    logic [5:0] fn_tab[10];

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        op_tab = '{O_R, O_J, O_BEQ, O_ADDI, O_ORI, O_LW, O_SW};
        fn_tab = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                   6'b100101, 6'b100111, 6'b101010, 6'b000000, 6'b111101};
        bus.opcode = 6'b0;
        bus.funct  = 6'b0;
        bus.zero   = 1'b0;
        reset      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        expect_cycle(4'd0, A_ADD, 1'b0, 2'b01, 2'b00, E_NONE);
        @(posedge clk);
        #1;
        reset = 1'b0;

        reset_mid_lw();
        run_instr(O_R, 6'b101010, 1'b0);
        run_instr(O_LW, 6'b000000, 1'b0);
        run_instr(O_BEQ, 6'b000000, 1'b1);
        run_instr(O_BEQ, 6'b000000, 1'b0);
        run_instr(6'b111111, 6'b000000, 1'b0);
        run_instr(O_SW, 6'b000000, 1'b1);
        run_instr(O_ADDI, 6'b000000, 1'b0);
        run_instr(O_ORI, 6'b000000, 1'b0);
        run_instr(O_J, 6'b000000, 1'b0);
        for (int i = 0; i < 10; i++) run_instr(O_R, fn_tab[i], 1'b0);

        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom_range(0, 63));
                while (op == O_R || op == O_J || op == O_BEQ || op == O_ADDI ||
                       op == O_ORI || op == O_LW || op == O_SW)
                    op = 6'($urandom_range(0, 63));
            end else begin
                op = op_tab[$urandom_range(0, 6)];
            end
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : fn_tab[$urandom_range(0, 9)];
            if ($urandom_range(0, 15) == 0) reset_mid_lw();
            run_instr(op, fn, 1'($urandom_range(0, 1)));
        end

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain actual=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
